vga_sync_decoder: RTL and testbench

Receive-side counterpart to `vga_control`. It takes a VGA hsync/vsync pair and recovers the pixel column and row from it, then qualifies the timing over successive frames and reports lock. It sits downstream of any sync source, for example `vga_control` itself or an external video input. Lock and recovered coordinates drive overlay and capture logic, and serve as an in-system checker for the timing generator.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 46 ++++
 rtl/vga_sync_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and decoder state encoding shared by the VGA
// blocks (vga_control on the transmit side, vga_sync_decoder on the receive
// side).
//
// Contents:
//   VGA_*         640x480 @ 60 Hz timing, in pixel ticks and lines
//   dec_state_t   decoder qualification state (SEARCH=0, TRACK=1, LOCKED=2)
//   in_range()    window test used for the active-area decode
package vga_pkg;

   localparam int VGA_H_TOTAL  = 800;
   localparam int VGA_H_START  = 144;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_V_TOTAL  = 525;
   localparam int VGA_V_START  = 35;
   localparam int VGA_V_ACTIVE = 480;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } dec_state_t;

   // True when start <= cnt < start + len.
   function automatic logic in_range(input logic [9:0] cnt, input int start, input int len);
      return (int'(cnt) >= start) && (int'(cnt) < start + len);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings one asynchronous sync line into the clock domain and
// flags its leading (inactive-to-active) edge.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ce         pixel-rate enable; every register advances only when high
//   sync_raw   sync input as seen on the pin
//   lead_edge  one-tick pulse (qualified by ce) on a leading edge
//
// Parameter ACTIVE_LOW selects the pin polarity. The pin is normalized to
// active-high ahead of the synchronizer so that the all-zero reset state of
// the flops means "inactive"; a pin that idles active-low therefore cannot
// produce a false edge on the first tick after reset.
module sync_edge_det #(
   parameter int ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic sync_raw,
   output logic lead_edge
);

   logic sync_norm;
   logic sync_s1;
   logic sync_s2;
   logic sync_prev;

   assign sync_norm = (ACTIVE_LOW != 0) ? ~sync_raw : sync_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_s1   <= 1'b0;
         sync_s2   <= 1'b0;
         sync_prev <= 1'b0;
      end else if (ce) begin
         sync_s1   <= sync_norm;
         sync_s2   <= sync_s1;
         sync_prev <= sync_s2;
      end
   end

   assign lead_edge = ce & sync_s2 & ~sync_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel column/row from an hsync/vsync pair,
// measures line and frame lengths, and qualifies the timing over successive
// frames before reporting lock.
//
// Ports:
//   clk_50         system clock
//   rst            asynchronous active-low reset
//   pix_ce         pixel-rate enable; all state advances only when high
//   horiz_sync_in  hsync pin
//   vert_sync_in   vsync pin
//   pixel_column   recovered column, 0 outside the active window
//   pixel_row      recovered row, 0 outside the active window
//   video_on       locked and inside the active window
//   locked         timing qualified (FSM in LOCKED)
//   line_err       one-tick pulse: measured line length differs from H_TOTAL
//   frame_err      one-tick pulse: measured frame length differs from V_TOTAL
//   lost_lock      one-tick pulse on LOCKED -> SEARCH
//   h_meas         last measured line length (0 unless VGA_DEC_MEAS_EN)
//   v_meas         last measured frame length (0 unless VGA_DEC_MEAS_EN)
//   fsm_state      current qualification state (dec_state_t encoding)
//
// Build option: define VGA_DEC_MEAS_EN to keep the h_meas/v_meas registers;
// without it both ports read 0 and lock/error behaviour is identical.
//
// Latency: a pin change is sampled on tick n, and the counter it resets reads
// 0 after tick n+2. Pixel data must be delayed by 2 ticks to line up.
module vga_sync_decoder
   import vga_pkg::*;
#(
   parameter int H_TOTAL         = VGA_H_TOTAL,
   parameter int H_START         = VGA_H_START,
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int V_TOTAL         = VGA_V_TOTAL,
   parameter int V_START         = VGA_V_START,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       pix_ce,
   input  logic       horiz_sync_in,
   input  logic       vert_sync_in,
   output logic [9:0] pixel_column,
   output logic [9:0] pixel_row,
   output logic       video_on,
   output logic       locked,
   output logic       line_err,
   output logic       frame_err,
   output logic       lost_lock,
   output logic [9:0] h_meas,
   output logic [9:0] v_meas,
   output logic [1:0] fsm_state
);

   logic        h_edge;
   logic        v_edge;
   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic        vpend;
   logic        v_reset;
   logic [10:0] line_len;
   logic [10:0] frame_len;
   logic        line_bad;
   logic        frame_bad;
   logic        watchdog;
   logic        in_win;

   dec_state_t  state;
   dec_state_t  state_n;
   logic [3:0]  good;
   logic [3:0]  good_n;
   logic        skip_line;
   logic        skip_n;
   logic        frame_bad_acc;
   logic        acc_n;
   logic        lost_n;

   sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync (
      .clk       (clk_50),
      .rst_n     (rst),
      .ce        (pix_ce),
      .sync_raw  (horiz_sync_in),
      .lead_edge (h_edge)
   );

   sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync (
      .clk       (clk_50),
      .rst_n     (rst),
      .ce        (pix_ce),
      .sync_raw  (vert_sync_in),
      .lead_edge (v_edge)
   );

   // A frame boundary is always taken on an hsync edge: either the one
   // coinciding with the vsync edge, or the first one after it (vpend).
   assign v_reset   = h_edge & (vpend | v_edge);
   assign line_len  = {1'b0, hcnt} + 11'd1;
   assign frame_len = {1'b0, vcnt} + 11'd1;
   assign watchdog  = (hcnt == 10'h3FF);

   // The line closing at the first hsync edge after entering TRACK started
   // before qualification began, so it is not judged.
   assign line_bad  = h_edge && (state != ST_SEARCH) && !skip_line &&
                      (line_len != 11'(H_TOTAL));
   assign frame_bad = v_reset && (state != ST_SEARCH) &&
                      (frame_len != 11'(V_TOTAL));

   always_ff @(posedge clk_50 or negedge rst) begin
      if (!rst) begin
         hcnt  <= '0;
         vcnt  <= '0;
         vpend <= 1'b0;
      end else if (pix_ce) begin
         if (h_edge) begin
            hcnt <= '0;
         end else if (hcnt != 10'h3FF) begin
            hcnt <= hcnt + 10'd1;
         end
         if (v_reset) begin
            vcnt  <= '0;
            vpend <= 1'b0;
         end else begin
            if (h_edge) vcnt  <= vcnt + 10'd1;
            if (v_edge) vpend <= 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      good_n  = good;
      skip_n  = skip_line;
      acc_n   = frame_bad_acc;
      lost_n  = 1'b0;

      if (h_edge)   skip_n = 1'b0;
      if (line_bad) acc_n  = 1'b1;
      if (v_reset)  acc_n  = 1'b0;

      case (state)
         ST_SEARCH: begin
            if (v_reset) begin
               state_n = ST_TRACK;
               good_n  = '0;
               skip_n  = 1'b1;
            end
         end
         ST_TRACK: begin
            if (v_reset) begin
               // The closing line's error is not in the accumulator yet.
               if (!frame_bad_acc && !line_bad && !frame_bad) begin
                  good_n = good + 4'd1;
                  if (good + 4'd1 == 4'(LOCK_FRAMES)) state_n = ST_LOCKED;
               end else begin
                  good_n = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (line_bad || frame_bad) begin
               state_n = ST_SEARCH;
               lost_n  = 1'b1;
            end
         end
         default: state_n = ST_SEARCH;
      endcase

      // A stalled hsync overrides everything else, in every state.
      if (watchdog) begin
         state_n = ST_SEARCH;
         lost_n  = (state == ST_LOCKED);
      end
   end

   always_ff @(posedge clk_50 or negedge rst) begin
      if (!rst) begin
         state         <= ST_SEARCH;
         good          <= '0;
         skip_line     <= 1'b0;
         frame_bad_acc <= 1'b0;
         line_err      <= 1'b0;
         frame_err     <= 1'b0;
         lost_lock     <= 1'b0;
      end else if (pix_ce) begin
         state         <= state_n;
         good          <= good_n;
         skip_line     <= skip_n;
         frame_bad_acc <= acc_n;
         line_err      <= line_bad;
         frame_err     <= frame_bad;
         lost_lock     <= lost_n;
      end
   end

`ifdef VGA_DEC_MEAS_EN
   logic [9:0] h_meas_q;
   logic [9:0] v_meas_q;

   always_ff @(posedge clk_50 or negedge rst) begin
      if (!rst) begin
         h_meas_q <= '0;
         v_meas_q <= '0;
      end else if (pix_ce) begin
         if (h_edge)  h_meas_q <= line_len[9:0];
         if (v_reset) v_meas_q <= frame_len[9:0];
      end
   end

   assign h_meas = h_meas_q;
   assign v_meas = v_meas_q;
`else
   assign h_meas = '0;
   assign v_meas = '0;
`endif

   assign in_win       = in_range(hcnt, H_START, H_ACTIVE) &&
                         in_range(vcnt, V_START, V_ACTIVE);
   assign pixel_column = in_win ? (hcnt - 10'(H_START)) : '0;
   assign pixel_row    = in_win ? (vcnt - 10'(V_START)) : '0;
   assign locked       = (state == ST_LOCKED);
   assign video_on     = locked & in_win;
   assign fsm_state    = state;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder using a reduced
// raster (40 ticks x 20 lines, 20x10 active) so several frames fit in a short
// run. Sync pins are active-low; hsync is 4 ticks wide, vsync 2 lines.
//
// Tick coordinates (line l, tick t) are those of the driven stream: hsync
// starts at t=0 and vsync at l=0, t=0. With 2 ticks of latency the decoder
// counters read hcnt = t-2 and vcnt = l (for t>=2) after each tick, so the
// first active pixel is (l=4, t=12) and the last is (l=13, t=31).
module tb_vga_sync_decoder;

   localparam int HT  = 40;
   localparam int HS  = 10;
   localparam int HA  = 20;
   localparam int VT  = 20;
   localparam int VS  = 4;
   localparam int VA  = 10;
   localparam int HSW = 4;
   localparam int VSW = 2;

   logic       clk_50;
   logic       rst;
   logic       pix_ce;
   logic       horiz_sync_in;
   logic       vert_sync_in;
   logic [9:0] pixel_column;
   logic [9:0] pixel_row;
   logic       video_on;
   logic       locked;
   logic       line_err;
   logic       frame_err;
   logic       lost_lock;
   logic [9:0] h_meas;
   logic [9:0] v_meas;
   logic [1:0] fsm_state;

   int checks;
   int failures;
   int snap_col [3];
   int snap_row [3];
   int snap_von [3];

   vga_sync_decoder #(
      .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
      .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
   ) dut (
      .clk_50        (clk_50),
      .rst           (rst),
      .pix_ce        (pix_ce),
      .horiz_sync_in (horiz_sync_in),
      .vert_sync_in  (vert_sync_in),
      .pixel_column  (pixel_column),
      .pixel_row     (pixel_row),
      .video_on      (video_on),
      .locked        (locked),
      .line_err      (line_err),
      .frame_err     (frame_err),
      .lost_lock     (lost_lock),
      .h_meas        (h_meas),
      .v_meas        (v_meas),
      .fsm_state     (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk_50 = 1'b0;
      forever #10 clk_50 = ~clk_50;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   // ---------------- drivers ----------------
   // One pixel tick: pix_ce high for one clock, low for the next. Returns at
   // a falling edge, so outputs are read half a clock away from any posedge.
   task automatic pix_tick(input logic hs_act, input logic vs_act);
      @(negedge clk_50);
      horiz_sync_in = ~hs_act;
      vert_sync_in  = ~vs_act;
      pix_ce        = 1'b1;
      @(negedge clk_50);
      pix_ce        = 1'b0;
   endtask

   // Streams n clean frames (frame 0 may carry one line of HT-1 ticks) and
   // records what it sees; k counts ticks from the first one driven.
   task automatic stream_frames(input int n, input int short_line,
                                output int rise_at, output int lost_at,
                                output int lost_cnt, output int lerr_cnt,
                                output int ferr_cnt, output int von_last);
      int   k;
      int   len;
      logic prev_locked;
      k = 0; rise_at = -1; lost_at = -1;
      lost_cnt = 0; lerr_cnt = 0; ferr_cnt = 0; von_last = 0;
      prev_locked = locked;
      for (int f = 0; f < n; f++) begin
         for (int l = 0; l < VT; l++) begin
            len = (f == 0 && l == short_line) ? HT - 1 : HT;
            for (int t = 0; t < len; t++) begin
               pix_tick(t < HSW, l < VSW);
               if (locked && !prev_locked && rise_at < 0) rise_at = k;
               prev_locked = locked;
               if (lost_lock) begin
                  lost_cnt++;
                  if (lost_at < 0) lost_at = k;
               end
               if (line_err)  lerr_cnt++;
               if (frame_err) ferr_cnt++;
               if (f == n - 1) begin
                  if (video_on) von_last++;
                  if (l == 4 && t == 12) begin
                     snap_col[0] = int'(pixel_column); snap_row[0] = int'(pixel_row); snap_von[0] = int'(video_on);
                  end
                  if (l == 13 && t == 31) begin
                     snap_col[1] = int'(pixel_column); snap_row[1] = int'(pixel_row); snap_von[1] = int'(video_on);
                  end
                  if (l == 4 && t == 11) begin
                     snap_col[2] = int'(pixel_column); snap_row[2] = int'(pixel_row); snap_von[2] = int'(video_on);
                  end
               end
               k++;
            end
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (4) pix_tick(1'b0, 1'b0);
      checks++; if (pixel_column !== 10'd0) begin failures++; $display("FAIL reset_col: got %0d expected 0", pixel_column); end
      checks++; if (pixel_row !== 10'd0) begin failures++; $display("FAIL reset_row: got %0d expected 0", pixel_row); end
      checks++; if (video_on !== 1'b0) begin failures++; $display("FAIL reset_video_on: got %b expected 0", video_on); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (line_err !== 1'b0) begin failures++; $display("FAIL reset_line_err: got %b expected 0", line_err); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (lost_lock !== 1'b0) begin failures++; $display("FAIL reset_lost_lock: got %b expected 0", lost_lock); end
      checks++; if (h_meas !== 10'd0) begin failures++; $display("FAIL reset_h_meas: got %0d expected 0", h_meas); end
      checks++; if (v_meas !== 10'd0) begin failures++; $display("FAIL reset_v_meas: got %0d expected 0", v_meas); end
      checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
      rst = 1'b1;
   endtask

   task automatic test_lock_coords();
      int rise_at, lost_at, lost_cnt, lerr_cnt, ferr_cnt, von_last;
      stream_frames(4, -1, rise_at, lost_at, lost_cnt, lerr_cnt, ferr_cnt, von_last);
      checks++; if (rise_at != 2 * HT * VT + 2) begin failures++; $display("FAIL lock_rise_tick: got %0d expected %0d", rise_at, 2 * HT * VT + 2); end
      checks++; if (lost_cnt != 0) begin failures++; $display("FAIL lock_lost_pulses: got %0d expected 0", lost_cnt); end
      checks++; if (lerr_cnt != 0) begin failures++; $display("FAIL lock_line_err_pulses: got %0d expected 0", lerr_cnt); end
      checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL lock_frame_err_pulses: got %0d expected 0", ferr_cnt); end
      checks++; if (von_last != HA * VA) begin failures++; $display("FAIL video_on_count: got %0d expected %0d", von_last, HA * VA); end
      checks++; if (snap_col[0] != 0 || snap_row[0] != 0 || snap_von[0] != 1) begin failures++; $display("FAIL first_pixel: got col=%0d row=%0d von=%0d expected 0 0 1", snap_col[0], snap_row[0], snap_von[0]); end
      checks++; if (snap_col[1] != HA - 1 || snap_row[1] != VA - 1 || snap_von[1] != 1) begin failures++; $display("FAIL last_pixel: got col=%0d row=%0d von=%0d expected %0d %0d 1", snap_col[1], snap_row[1], snap_von[1], HA - 1, VA - 1); end
      checks++; if (snap_col[2] != 0 || snap_von[2] != 0) begin failures++; $display("FAIL pre_window: got col=%0d von=%0d expected 0 0", snap_col[2], snap_von[2]); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_held: got %b expected 1", locked); end
`ifdef VGA_DEC_MEAS_EN
      checks++; if (h_meas !== 10'd40) begin failures++; $display("FAIL h_meas: got %0d expected 40", h_meas); end
      checks++; if (v_meas !== 10'd20) begin failures++; $display("FAIL v_meas: got %0d expected 20", v_meas); end
`else
      checks++; if (h_meas !== 10'd0) begin failures++; $display("FAIL h_meas_off: got %0d expected 0", h_meas); end
      checks++; if (v_meas !== 10'd0) begin failures++; $display("FAIL v_meas_off: got %0d expected 0", v_meas); end
`endif
   endtask

   task automatic test_mid_reset();
      int bad_ticks;
      int rise_at, lost_at, lost_cnt, lerr_cnt, ferr_cnt, von_last;
      for (int l = 0; l <= 8; l++) begin
         for (int t = 0; t < ((l == 8) ? 21 : HT); t++) pix_tick(t < HSW, l < VSW);
      end
      // (l=8, t=20): hcnt=18, vcnt=8 -> column 8, row 4.
      checks++; if (video_on !== 1'b1 || pixel_column !== 10'd8 || pixel_row !== 10'd4) begin failures++; $display("FAIL pre_reset_pixel: got von=%b col=%0d row=%0d expected 1 8 4", video_on, pixel_column, pixel_row); end
      #3 rst = 1'b0;
      #1;
      checks++; if (locked !== 1'b0 || video_on !== 1'b0) begin failures++; $display("FAIL async_reset_lock: got locked=%b von=%b expected 0 0", locked, video_on); end
      checks++; if (pixel_column !== 10'd0 || pixel_row !== 10'd0) begin failures++; $display("FAIL async_reset_coords: got col=%0d row=%0d expected 0 0", pixel_column, pixel_row); end
      checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL async_reset_state: got %0d expected 0", fsm_state); end
      bad_ticks = 0;
      for (int l = 8; l < VT; l++) begin
         for (int t = (l == 8) ? 21 : 0; t < HT; t++) begin
            if (l == 8 && t == 24) rst = 1'b1;
            pix_tick(t < HSW, l < VSW);
            if (locked || video_on || line_err || frame_err || lost_lock) bad_ticks++;
         end
      end
      checks++; if (bad_ticks != 0) begin failures++; $display("FAIL post_reset_quiet: got %0d active ticks expected 0", bad_ticks); end
      stream_frames(3, -1, rise_at, lost_at, lost_cnt, lerr_cnt, ferr_cnt, von_last);
      checks++; if (rise_at != 2 * HT * VT + 2) begin failures++; $display("FAIL relock_after_reset: got %0d expected %0d", rise_at, 2 * HT * VT + 2); end
      checks++; if (lost_cnt + lerr_cnt + ferr_cnt != 0) begin failures++; $display("FAIL relock_pulses: got %0d expected 0", lost_cnt + lerr_cnt + ferr_cnt); end
   endtask

   task automatic test_line_err();
      int rise_at, lost_at, lost_cnt, lerr_cnt, ferr_cnt, von_last;
      // Line 5 is HT-1 ticks; line 6 begins at tick 239, its edge lands at 241.
      stream_frames(4, 5, rise_at, lost_at, lost_cnt, lerr_cnt, ferr_cnt, von_last);
      checks++; if (lost_at != 241) begin failures++; $display("FAIL short_line_lost_at: got %0d expected 241", lost_at); end
      checks++; if (lost_cnt != 1) begin failures++; $display("FAIL short_line_lost_cnt: got %0d expected 1", lost_cnt); end
      checks++; if (lerr_cnt != 1) begin failures++; $display("FAIL short_line_err_cnt: got %0d expected 1", lerr_cnt); end
      checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL short_line_frame_err: got %0d expected 0", ferr_cnt); end
      checks++; if (rise_at != 3 * HT * VT + 1) begin failures++; $display("FAIL short_line_relock: got %0d expected %0d", rise_at, 3 * HT * VT + 1); end
   endtask

   task automatic test_watchdog();
      int lost_cnt;
      lost_cnt = 0;
      // Entering with hcnt=37; it saturates at tick 986 of the hold.
      for (int k = 1; k <= 1100; k++) begin
         pix_tick(1'b0, 1'b0);
         if (lost_lock) lost_cnt++;
         if (k == 900) begin
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL wd_early: got locked=%b expected 1", locked); end
         end
      end
      checks++; if (lost_cnt != 1) begin failures++; $display("FAIL wd_lost_cnt: got %0d expected 1", lost_cnt); end
      checks++; if (locked !== 1'b0 || video_on !== 1'b0) begin failures++; $display("FAIL wd_unlocked: got locked=%b von=%b expected 0 0", locked, video_on); end
      checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL wd_state: got %0d expected 0", fsm_state); end
   endtask

   task automatic test_vsync_midline();
      logic vs;
      // Frame with vsync starting mid-line 0 (t=20) and ending mid-line 2.
      for (int l = 0; l < VT; l++) begin
         for (int t = 0; t < HT; t++) begin
            vs = (l == 0 && t >= 20) || (l == 1) || (l == 2 && t < 20);
            pix_tick(t < HSW, vs);
            if (l == 0 && t == 39) begin
               checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL midline_wait: got %0d expected 0", fsm_state); end
            end
            if (l == 1 && t == 2) begin
               checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL midline_track: got %0d expected 1", fsm_state); end
            end
            if (l == 5 && t == 12) begin
               checks++; if (pixel_row !== 10'd0 || pixel_column !== 10'd0) begin failures++; $display("FAIL midline_row0: got row=%0d col=%0d expected 0 0", pixel_row, pixel_column); end
            end
            if (l == 6 && t == 12) begin
               checks++; if (pixel_row !== 10'd1) begin failures++; $display("FAIL midline_row1: got %0d expected 1", pixel_row); end
            end
         end
      end
      // Aligned frame: vsync and hsync edges coincide; previous frame was 19 lines.
      for (int l = 0; l < VT; l++) begin
         for (int t = 0; t < HT; t++) begin
            pix_tick(t < HSW, l < VSW);
            if (l == 0 && t == 1) begin
               checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_err_early: got %b expected 0", frame_err); end
            end
            if (l == 0 && t == 2) begin
               checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_err_pulse: got %b expected 1", frame_err); end
               checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL frame_err_state: got %0d expected 1", fsm_state); end
            end
            if (l == 4 && t == 12) begin
               checks++; if (pixel_row !== 10'd0) begin failures++; $display("FAIL sametick_row0: got %0d expected 0", pixel_row); end
            end
            if (l == 7 && t == 12) begin
               checks++; if (pixel_row !== 10'd3) begin failures++; $display("FAIL sametick_row3: got %0d expected 3", pixel_row); end
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b0;
      pix_ce        = 1'b0;
      horiz_sync_in = 1'b1;
      vert_sync_in  = 1'b1;
      test_reset();
      test_lock_coords();
      test_mid_reset();
      test_line_err();
      test_watchdog();
      test_vsync_midline();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
